fp16_sub_pipe: RTL and testbench

// - Pipelined IEEE-754 binary16 subtractor: result = a - b. Inverse operation of the

---
 rtl/fp16_sub_pipe.sv | 154 +++++++++++++++
 tb/tb_fp16_sub_pipe.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fp16_sub_pipe.sv
// Three-stage pipelined binary16 subtractor (result = a - b) with valid/ready on both sides.
// Define FP16_SUB_SPECIALS_EN for IEEE inf/NaN decoding; otherwise overflow saturates to max finite.
module fp16_sub_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result
);

    logic adv;

    // S1 combinational: flush, negate b, order by magnitude, align smaller operand
    logic [15:0] a_f, b_n, op_x, op_y;
    logic        swap;
    logic [4:0]  d;
    logic [13:0] y_ext, y_sh, mask;
    logic [1:0]  spec;
`ifdef FP16_SUB_SPECIALS_EN
    logic        nan_in;
`endif

    always_comb begin
        a_f   = (a[14:10] == 5'd0) ? {a[15], 15'd0} : a;
        b_n   = (b[14:10] == 5'd0) ? {~b[15], 15'd0} : {~b[15], b[14:0]};
        swap  = b_n[14:0] > a_f[14:0];
        op_x  = swap ? b_n : a_f;
        op_y  = swap ? a_f : b_n;
        d     = op_x[14:10] - op_y[14:10];
        y_ext = {|op_y[14:10], op_y[9:0], 3'b000};
        mask  = (14'd1 << d) - 14'd1;
        if (d >= 5'd13)
            y_sh = {13'd0, |y_ext};
        else
            y_sh = (y_ext >> d) | {13'd0, |(y_ext & mask)};
        spec = 2'b00;
`ifdef FP16_SUB_SPECIALS_EN
        // spec[1] = NaN result, spec[0] = infinite result carrying op_x sign
        nan_in  = (&a[14:10] & |a[9:0]) | (&b[14:10] & |b[9:0]);
        spec[1] = nan_in | (&op_x[14:10] & &op_y[14:10] & (op_x[15] ^ op_y[15]));
        spec[0] = &op_x[14:10];
`endif
    end

    // Stage registers
    logic        s1_v_q, s1_v_d, s1_sign_q, s1_sign_d, s1_sub_q, s1_sub_d;
    logic [4:0]  s1_exp_q, s1_exp_d;
    logic [13:0] s1_xm_q, s1_xm_d, s1_ym_q, s1_ym_d;
    logic [1:0]  s1_spec_q, s1_spec_d;
    logic        s2_v_q, s2_v_d, s2_sign_q, s2_sign_d, s2_sub_q, s2_sub_d;
    logic [4:0]  s2_exp_q, s2_exp_d;
    logic [14:0] s2_sum_q, s2_sum_d;
    logic [1:0]  s2_spec_q, s2_spec_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] result_q, result_d;

    // S3 combinational: normalise, round to nearest even, handle zero/underflow/overflow
    logic [3:0]        lz;
    logic [13:0]       norm;
    logic signed [6:0] e, e_r;
    logic              up;
    logic [10:0]       frac_r;
    logic [15:0]       res;
    logic              unused_bits;

    always_comb begin
        lz = 4'd0;
        for (int i = 0; i < 14; i++)
            if (s2_sum_q[i]) lz = 4'(13 - i);
        if (s2_sum_q[14]) begin
            norm = {s2_sum_q[14:2], s2_sum_q[1] | s2_sum_q[0]};
            e    = $signed({2'b00, s2_exp_q}) + 7'sd1;
        end else begin
            norm = s2_sum_q[13:0] << lz;
            e    = $signed({2'b00, s2_exp_q}) - $signed({3'b000, lz});
        end
        up     = norm[2] & (norm[1] | norm[0] | norm[3]);
        frac_r = {1'b0, norm[12:3]} + {10'd0, up};
        e_r    = frac_r[10] ? e + 7'sd1 : e;
        if (s2_sum_q == 15'd0)
            res = s2_sub_q ? 16'h0000 : {s2_sign_q, 15'd0};
        else if (e <= 7'sd0)
            res = {s2_sign_q, 15'd0};
        else if (e_r >= 7'sd31)
`ifdef FP16_SUB_SPECIALS_EN
            res = {s2_sign_q, 15'h7C00};
`else
            res = {s2_sign_q, 15'h7BFF};
`endif
        else
            res = {s2_sign_q, e_r[4:0], frac_r[9:0]};
        if (s2_spec_q[1])
            res = 16'h7E00;
        else if (s2_spec_q[0])
            res = {s2_sign_q, 15'h7C00};
    end

    assign unused_bits = ^{norm[13], e_r[6:5]};

    // Whole pipeline moves together; bubbles shift as well
    always_comb begin
        adv         = out_ready | ~out_valid_q;
        s1_v_d      = s1_v_q;      s1_sign_d = s1_sign_q; s1_sub_d  = s1_sub_q;
        s1_exp_d    = s1_exp_q;    s1_xm_d   = s1_xm_q;   s1_ym_d   = s1_ym_q;
        s1_spec_d   = s1_spec_q;
        s2_v_d      = s2_v_q;      s2_sign_d = s2_sign_q; s2_sub_d  = s2_sub_q;
        s2_exp_d    = s2_exp_q;    s2_sum_d  = s2_sum_q;  s2_spec_d = s2_spec_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        if (adv) begin
            s1_v_d      = in_valid;
            s1_sign_d   = op_x[15];
            s1_sub_d    = op_x[15] ^ op_y[15];
            s1_exp_d    = op_x[14:10];
            s1_xm_d     = {|op_x[14:10], op_x[9:0], 3'b000};
            s1_ym_d     = y_sh;
            s1_spec_d   = spec;
            s2_v_d      = s1_v_q;
            s2_sign_d   = s1_sign_q;
            s2_sub_d    = s1_sub_q;
            s2_exp_d    = s1_exp_q;
            s2_sum_d    = s1_sub_q ? ({1'b0, s1_xm_q} - {1'b0, s1_ym_q})
                                   : ({1'b0, s1_xm_q} + {1'b0, s1_ym_q});
            s2_spec_d   = s1_spec_q;
            out_valid_d = s2_v_q;
            if (s2_v_q) result_d = res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0; s1_sign_q <= 1'b0; s1_sub_q <= 1'b0; s1_exp_q <= 5'd0;
            s1_xm_q <= 14'd0; s1_ym_q <= 14'd0; s1_spec_q <= 2'b00;
            s2_v_q <= 1'b0; s2_sign_q <= 1'b0; s2_sub_q <= 1'b0; s2_exp_q <= 5'd0;
            s2_sum_q <= 15'd0; s2_spec_q <= 2'b00;
            out_valid_q <= 1'b0; result_q <= 16'h0000;
        end else begin
            s1_v_q <= s1_v_d; s1_sign_q <= s1_sign_d; s1_sub_q <= s1_sub_d; s1_exp_q <= s1_exp_d;
            s1_xm_q <= s1_xm_d; s1_ym_q <= s1_ym_d; s1_spec_q <= s1_spec_d;
            s2_v_q <= s2_v_d; s2_sign_q <= s2_sign_d; s2_sub_q <= s2_sub_d; s2_exp_q <= s2_exp_d;
            s2_sum_q <= s2_sum_d; s2_spec_q <= s2_spec_d;
            out_valid_q <= out_valid_d; result_q <= result_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_fp16_sub_pipe.sv
// Scoreboard bench for fp16_sub_pipe: expected differences are queued at input accept
// and compared in order at output transfer. Build with FP16_SUB_SPECIALS_EN to test that build.
module tb_fp16_sub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = 16'h0, b = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;

    logic [15:0] exp_in = 16'h0;
    logic [15:0] sb_q[$];
    logic [15:0] exp_pop;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_out = 0;

`ifdef FP16_SUB_SPECIALS_EN
    localparam logic [15:0] E_OVF = 16'h7C00, E_INF = 16'h7E00, E_NAN = 16'h7E00, E_NINF = 16'hFC00;
`else
    localparam logic [15:0] E_OVF = 16'h7BFF, E_INF = 16'h0000, E_NAN = 16'h7BFF, E_NINF = 16'hFBFF;
`endif
    localparam int NV = 19;
    localparam logic [15:0] VA [0:NV-1] = '{16'h3C00, 16'h4000, 16'h3C00, 16'hBC00, 16'h4B80,
        16'h3C00, 16'h0001, 16'h8000, 16'h4E00, 16'h3C00, 16'h3C00, 16'h0401, 16'h0400,
        16'h3C00, 16'h0000, 16'h7BFF, 16'h7C00, 16'h7E00, 16'h3C00};
    localparam logic [15:0] VB [0:NV-1] = '{16'h3C00, 16'h3C00, 16'h4000, 16'h3C00, 16'hCB80,
        16'h1000, 16'h0000, 16'h0000, 16'hCE00, 16'h0C00, 16'h9000, 16'h0400, 16'h0401,
        16'hBC00, 16'h3C00, 16'hFBFF, 16'h7C00, 16'h3C00, 16'h7C00};
    localparam logic [15:0] VE [0:NV-1] = '{16'h0000, 16'h3C00, 16'hBC00, 16'hC000, 16'h4F80,
        16'h3BFF, 16'h0000, 16'h8000, 16'h5200, 16'h3C00, 16'h3C00, 16'h0000, 16'h8000,
        16'h4000, 16'hBC00, E_OVF, E_INF, E_NAN, E_NINF};

    fp16_sub_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, want);
        end
    endtask

    // Monitor: inputs and outputs are stable at the falling edge and transfer on the next rise
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) sb_q.push_back(exp_in);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("spurious_out", {31'd0, out_valid}, 32'd0);
                end else begin
                    exp_pop = sb_q.pop_front();
                    n_out++;
                    $display("out %0d: result=%h expected=%h", n_out, result, exp_pop);
                    check("result", {16'd0, result}, {16'd0, exp_pop});
                end
            end
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] e);
        int t;
        a = x; b = y; exp_in = e; in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("drain", sb_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic lat_op(input int i);
        int n;
        send(VA[i], VB[i], VE[i]);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        check("latency", n, 32'd3);
        drain();
    endtask

    initial begin
        logic [15:0] held;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", {16'd0, result}, 32'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Single operations with latency measurement
        for (int i = 0; i < 4; i++) lat_op(i);

        // Back-to-back, one per clock
        for (int i = 0; i < NV; i++) send(VA[i], VB[i], VE[i]);
        drain();

        // Backpressure with three operations in flight
        out_ready = 1'b0;
        send(16'h4000, 16'h3C00, 16'h3C00);
        send(16'h4B80, 16'hCB80, 16'h4F80);
        send(16'h3C00, 16'h1000, 16'h3BFF);
        held = result;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold", {16'd0, result}, {16'd0, held});
        end
        check("bp_first", {16'd0, held}, 32'h3C00);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Random output throttling while streaming
        fork
            begin
                for (int i = 0; i < NV; i++) send(VA[i], VB[i], VE[i]);
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with two operations in flight
        send(16'h3C00, 16'h4000, 16'hBC00);
        send(16'hBC00, 16'h3C00, 16'hC000);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", {16'd0, result}, 32'h0000);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_idle", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        lat_op(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

endmodule
